// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing HI/LO results.
// Both operations work on operand magnitudes for WIDTH steps. A final FIX cycle
// then applies the sign correction.
// Optional feature: define MULT_DIV_UNIT_DIV0_TRAP_EN so that a divide by zero
// finishes immediately and raises div_zero.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q;
  logic                  is_div_q;
  logic                  neg_q_q;   // negate quotient, or the whole product
  logic                  neg_r_q;   // negate remainder
  logic [WIDTH-1:0]      opnd_q;    // |b|: multiplicand to add, or divisor
  logic [WIDTH-1:0]      acc_q;     // product high half / partial remainder
  logic [WIDTH-1:0]      sh_q;      // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0]      hi_q, lo_q;

  logic                  accept, signed_op, a_neg, b_neg, b_zero, trap;
  logic [WIDTH-1:0]      a_mag, b_mag;
  logic [WIDTH:0]        mul_sum, div_shift;
  logic [WIDTH-1:0]      div_diff;
  logic                  div_ge;
  logic [2*WIDTH-1:0]    prod, prod_fix;
  logic [WIDTH-1:0]      q_fix, r_fix;

  assign accept    = start && (state_q == StIdle || state_q == StDone);
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign b_zero    = (b == '0);
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One datapath step per RUN cycle plus the sign correction applied in FIX
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // Only used when div_ge is set, so the difference fits WIDTH bits
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    prod      = {acc_q, sh_q};
    prod_fix  = neg_q_q ? -prod : prod;
    q_fix     = neg_q_q ? -sh_q : sh_q;
    r_fix     = neg_r_q ? -acc_q : acc_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = trap ? StDone : StRun;
      StRun:   if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = start ? (trap ? StDone : StRun) : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register, operand latch, iteration and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_div_q <= op[1];
        // A zero divisor yields an all-ones quotient that must not be negated
        neg_q_q  <= (a_neg ^ b_neg) & ~(op[1] & b_zero);
        neg_r_q  <= a_neg;
        opnd_q   <= b_mag;
        acc_q    <= '0;
        sh_q     <= a_mag;
        cnt_q    <= '0;
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + CntW'(1);
        if (is_div_q) begin
          acc_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          sh_q  <= {sh_q[WIDTH-2:0], div_ge};
        end else begin
          acc_q <= mul_sum[WIDTH:1];
          sh_q  <= {mul_sum[0], sh_q[WIDTH-1:1]};
        end
      end else if (state_q == StFix) begin
        if (is_div_q) begin
          hi_q <= r_fix;
          lo_q <= q_fix;
        end else begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

`ifdef MULT_DIV_UNIT_DIV0_TRAP_EN
  logic dz_q;

  assign trap = op[1] & b_zero;

  // Divide-by-zero flag, refreshed on every accepted start
  always_ff @(posedge clock) begin
    if (reset) begin
      dz_q <= 1'b0;
    end else if (accept) begin
      dz_q <= trap;
    end
  end

  assign div_zero = dz_q;
`else
  assign trap     = 1'b0;
  assign div_zero = 1'b0;
`endif

  assign busy = (state_q == StRun) || (state_q == StFix);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH = 32) against an arithmetic model.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", name, got, expv);
    end
  endtask

  // Reference: plain wide arithmetic. Division by zero follows the configured behaviour.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l,
                                output logic dz, output int lat);
    logic signed [63:0] sx, sy, p, q, r;
    sx  = {{32{x[W-1]}}, x};
    sy  = {{32{y[W-1]}}, y};
    dz  = 1'b0;
    lat = LAT;
    h   = exp_hi;
    l   = exp_lo;
    if (o == 2'd0) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else if (o == 2'd1) begin
      p = {32'b0, x} * {32'b0, y};
      h = p[63:32];
      l = p[31:0];
    end else if (y == '0) begin
`ifdef MULT_DIV_UNIT_DIV0_TRAP_EN
      dz  = 1'b1;
      lat = 1;
`else
      h = x;
      l = '1;
`endif
    end else if (o == 2'd2) begin
      q = sx / sy;
      r = sx % sy;
      h = r[31:0];
      l = q[31:0];
    end else begin
      q = {32'b0, x} / {32'b0, y};
      r = {32'b0, x} % {32'b0, y};
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  // Issue one operation and wait for done. Inputs are scrambled while it runs.
  // inj > 0 pulses a fresh start after that many edges.
  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input int inj, input string tag);
    logic [W-1:0] h, l;
    logic         dz;
    int           lat, edges, busy_n;
    model(o, x, y, h, l, dz, lat);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    edges  = 1;
    busy_n = 0;
    while (!done && edges < LAT + 8) begin
      if (busy) busy_n++;
      a     = $urandom;
      b     = $urandom;
      op    = 2'($urandom_range(0, 3));
      start = (edges == inj);
      @(posedge clock);
      #1;
      edges++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(lat - 1));
    check({tag, " hi"}, 64'(hi), 64'(h));
    check({tag, " lo"}, 64'(lo), 64'(l));
    check({tag, " div_zero"}, 64'(div_zero), 64'(dz));
    exp_hi = h;
    exp_lo = l;
    exp_dz = dz;
  endtask

  task automatic idle(input string tag);
    @(posedge clock);
    #1;
    check({tag, " done pulse ends"}, 64'(done), 64'(0));
    check({tag, " idle busy"}, 64'(busy), 64'(0));
    check({tag, " hi held"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo held"}, 64'(lo), 64'(exp_lo));
    check({tag, " div_zero held"}, 64'(div_zero), 64'(exp_dz));
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset div_zero", 64'(div_zero), 64'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;

    run(2'd0, 32'hFFFF_FFFD, 32'd7, 0, "mult neg*pos");
    idle("mult neg*pos");
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu max");
    run(2'd3, 32'd100, 32'd7, 0, "divu back-to-back");
    idle("divu back-to-back");
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
    idle("div -7/2");
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div min/-1");
    idle("div min/-1");
    run(2'd3, 32'd5, 32'd0, 0, "divu 5/0");
    idle("divu 5/0");
    run(2'd2, 32'hFFFF_FF00, 32'd0, 0, "div neg/0");
    run(2'd0, 32'd3, 32'd4, 0, "mult after div0");
    idle("mult after div0");
    run(2'd0, $urandom, $urandom, 5, "start ignored in run");
    idle("start ignored in run");

    // Abort a multiply in RUN cycle 10
    op    = 2'd1;
    a     = $urandom;
    b     = $urandom;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort hi", 64'(hi), 64'(0));
    check("abort lo", 64'(lo), 64'(0));
    exp_hi    = '0;
    exp_lo    = '0;
    exp_dz    = 1'b0;
    done_seen = 0;
    repeat (LAT + 6) begin
      @(posedge clock);
      #1;
      if (done) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'(0));

    for (int i = 0; i < 24; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      run(o, x, y, 0, "random");
      if ($urandom_range(0, 1) == 1) idle("random");
    end
    idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
